uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART RX datapath. It synchronises the raw serial line, detects and qualifies the start bit on an oversampled tick, and issues mid-bit shift_en pulses to the datapath shift register. It checks the stop bit and then commands ld_data. It also owns the consumer handshake (rx_valid/rx_ready) and the frame and overrun error flags.

Parameters:
DATAWIDTH, 8, number of data bits per frame (LSB first); legal range 5..9
OVERSAMPLE, 16, bit_enb ticks per bit period; must be even and >= 4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
rx_in  input  1  raw serial line, asynchronous, idle high
bit_enb  input  1  one-clk tick at OVERSAMPLE x baud rate
rx_ready  input  1  consumer has taken the current word; clears rx_valid
shift_en  output  1  one-clk pulse: datapath shifts in sampled_bit
count_enb  output  1  high for the whole data phase (datapath bit counter enable)
ld_data  output  1  one-clk pulse: datapath transfers shift register to RX_DATA
sampled_bit  output  1  synchronised line value, fed to datapath serial_in
rx_valid  output  1  RX_DATA holds an unread word
frame_err  output  1  one-clk pulse: stop bit sampled low
overrun_err  output  1  one-clk pulse: new word loaded while previous was unread
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, tick_cnt=0, bit_cnt=0, sync flops=1. All outputs 0 except sampled_bit=1.
- Synchroniser: rx_in passes through a 2-flop sync to give rx_s. sampled_bit=rx_s. Line-to-rx_s latency is 2 clk.
- All outputs are registered. Each pulse asserts in the clk after the qualifying bit_enb cycle.
- tick_cnt advances only on bit_enb. bit_enb is ignored in IDLE and BRK.
- IDLE: rx_s==0 -> START, tick_cnt=0.
- START: on bit_enb with tick_cnt==OVERSAMPLE/2-1, test rx_s:
  - rx_s==0 -> DATA, tick_cnt=0, bit_cnt=0.
  - rx_s==1 -> IDLE (glitch rejected; no flag).
  - Otherwise tick_cnt++.
- DATA: count_enb=1 throughout. On bit_enb with tick_cnt==OVERSAMPLE-1:
  - shift_en pulse, tick_cnt=0, bit_cnt++.
  - When the pulse is for bit_cnt==DATAWIDTH-1 -> STOP.
  - Exactly DATAWIDTH shift_en pulses occur per frame.
- STOP: on bit_enb with tick_cnt==OVERSAMPLE-1, test rx_s:
  - rx_s==1 -> ld_data pulse, -> IDLE.
  - rx_s==0 -> frame_err pulse, no ld_data, -> BRK.
- BRK: wait until rx_s==1, then -> IDLE. Prevents a held-low break from re-triggering START.
- rx_valid: set the clk after ld_data; cleared in the clk after rx_ready=1.
  - rx_ready while rx_valid=0: no effect.
  - ld_data while rx_valid=1 and rx_ready=0: overrun_err pulse (same clk as rx_valid refresh); rx_valid stays 1; new data overwrites.
  - ld_data and rx_ready in the same clk: rx_valid stays 1; no overrun.
- Back-to-back frames: a start edge is accepted from the first IDLE cycle after STOP. There is no dead time beyond 1 clk.
- Reset mid-frame: immediate return to reset state. Pending rx_valid is lost and no pulses are emitted.
- Counters: tick_cnt width clog2(OVERSAMPLE); bit_cnt width clog2(DATAWIDTH+1). Neither may wrap within a frame.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum: IDLE, START, DATA, STOP, BRK.
  - Default DATAWIDTH and OVERSAMPLE constants.
  - A clog2 helper function.
- One natural sub-module: sync_2ff (2-flop synchroniser, reset value parameterised, here 1). It is reused by the TX side.

Test Plan:
1. Defaults; bit_enb every 4 clk; send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> 8 shift_en pulses spaced 64 clk; sampled bits 1,0,1,0,0,1,0,1; then one ld_data, rx_valid=1, frame_err=0.
2. rx_in low for 3 bit_enb ticks (< 8) then high -> START then IDLE; no shift_en, busy deasserts, no errors.
3. Frame 0x3C with stop bit 0, line held low 40 ticks -> 8 shift_en, frame_err pulse, no ld_data; stays in BRK until line high, then IDLE.
4. Two frames 0x11 then 0x22 with rx_ready=0 -> second ld_data gives overrun_err pulse, rx_valid stays 1. Then rx_ready=1 for 1 clk -> rx_valid=0 next clk.
5. rx_ready=1 asserted in the same clk as ld_data of a second frame -> rx_valid stays 1, overrun_err=0.
6. rst=0 asserted asynchronously after the 4th shift_en of 0xF0 -> outputs clear immediately. After release, a clean frame 0x0F receives correctly with 8 shift_en.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: RX sequencer states, default frame geometry,
// and a constant-evaluable ceil(log2) helper for sizing counters.
package uart_pkg;

    localparam int unsigned DATAWIDTH_DEF  = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_t;

    // Smallest r with 2**r >= value (value >= 2 for meaningful widths).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high line does not look
// like a start edge while coming out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronises the serial line, qualifies the start
// bit at mid-bit, issues mid-bit shift pulses, checks the stop bit, and owns
// the rx_valid/rx_ready handshake plus frame and overrun error pulses.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = DATAWIDTH_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    input  logic bit_enb,
    input  logic rx_ready,
    output logic shift_en,
    output logic count_enb,
    output logic ld_data,
    output logic sampled_bit,
    output logic rx_valid,
    output logic frame_err,
    output logic overrun_err,
    output logic busy
);

    localparam int unsigned TW = clog2(OVERSAMPLE);
    localparam int unsigned BW = clog2(DATAWIDTH + 1);

    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATAWIDTH - 1);

    logic          rx_s;
    rx_state_t     state_q,       state_d;
    logic [TW-1:0] tick_cnt_q,    tick_cnt_d;
    logic [BW-1:0] bit_cnt_q,     bit_cnt_d;
    logic          shift_en_q,    shift_en_d;
    logic          count_enb_q,   count_enb_d;
    logic          ld_data_q,     ld_data_d;
    logic          rx_valid_q,    rx_valid_d;
    logic          frame_err_q,   frame_err_d;
    logic          overrun_err_q, overrun_err_d;
    logic          busy_q,        busy_d;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst),
        .d    (rx_in),
        .q    (rx_s)
    );

    // Next-state, counters and frame pulses; counters move only on bit_enb.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_en_d  = 1'b0;
        ld_data_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (bit_enb) begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (!rx_s) begin
                            state_d    = DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_enb) begin
                    if (tick_cnt_q == TICK_END) begin
                        shift_en_d = 1'b1;
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_enb) begin
                    if (tick_cnt_q == TICK_END) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            ld_data_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BRK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            BRK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        count_enb_d = (state_d == DATA);
        busy_d      = (state_d != IDLE);
    end

    // Consumer handshake: a load wins over rx_ready, so a word loaded in the
    // same clk as rx_ready stays valid and does not count as an overrun.
    always_comb begin
        rx_valid_d    = rx_valid_q;
        overrun_err_d = 1'b0;
        if (ld_data_q) begin
            rx_valid_d    = 1'b1;
            overrun_err_d = rx_valid_q && !rx_ready;
        end else if (rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_en_q    <= 1'b0;
            count_enb_q   <= 1'b0;
            ld_data_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_en_q    <= shift_en_d;
            count_enb_q   <= count_enb_d;
            ld_data_q     <= ld_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            busy_q        <= busy_d;
        end
    end

    assign shift_en    = shift_en_q;
    assign count_enb   = count_enb_q;
    assign ld_data     = ld_data_q;
    assign sampled_bit = rx_s;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: 8 data bits, 16x oversample, bit_enb every 4 clk.
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rx_in;
  logic bit_enb;
  logic rx_ready;
  logic shift_en;
  logic count_enb;
  logic ld_data;
  logic sampled_bit;
  logic rx_valid;
  logic frame_err;
  logic overrun_err;
  logic busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned cyc     = 0;
  int unsigned n_shift = 0;
  int unsigned n_ld    = 0;
  int unsigned n_fe    = 0;
  int unsigned n_ov    = 0;
  int unsigned n_cen   = 0;
  logic        shift_bits [0:255];
  int unsigned shift_time [0:255];

  uart_rx_ctrl #(
    .DATAWIDTH (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .bit_enb    (bit_enb),
    .rx_ready   (rx_ready),
    .shift_en   (shift_en),
    .count_enb  (count_enb),
    .ld_data    (ld_data),
    .sampled_bit(sampled_bit),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    bit_enb = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bit_enb = 1'b1;
      @(posedge clk);
      #1 bit_enb = 1'b0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (shift_en === 1'b1) begin
      shift_bits[8'(n_shift)] = sampled_bit;
      shift_time[8'(n_shift)] = cyc;
      n_shift++;
    end
    if (ld_data === 1'b1)     n_ld++;
    if (frame_err === 1'b1)   n_fe++;
    if (overrun_err === 1'b1) n_ov++;
    if (count_enb === 1'b1)   n_cen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      while (bit_enb !== 1'b1) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_head(input logic [7:0] data);
    rx_in = 1'b0;
    wait_ticks(16);
    for (int unsigned i = 0; i < 8; i++) begin
      rx_in = data[i];
      wait_ticks(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    send_head(data);
    rx_in = stop_bit;
    wait_ticks(16);
  endtask

  function automatic logic [7:0] get_byte(input int unsigned base);
    logic [7:0] b;
    b = '0;
    for (int unsigned i = 0; i < 8; i++) b[i] = shift_bits[8'(base + i)];
    return b;
  endfunction

  initial begin
    int unsigned s_sh, s_ld, s_fe, s_ov, s_cen, n;

    rst      = 1'b0;
    rx_in    = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (shift_en !== 1'b0) begin bad++; $error("FAIL rst_shift_en: %0h", shift_en); end
    total++; if (count_enb !== 1'b0) begin bad++; $error("FAIL rst_count_enb: %0h", count_enb); end
    total++; if (ld_data !== 1'b0) begin bad++; $error("FAIL rst_ld_data: %0h", ld_data); end
    total++; if (sampled_bit !== 1'b1) begin bad++; $error("FAIL rst_sampled_bit: %0h", sampled_bit); end
    total++; if (rx_valid !== 1'b0) begin bad++; $error("FAIL rst_rx_valid: %0h", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $error("FAIL rst_frame_err: %0h", frame_err); end
    total++; if (overrun_err !== 1'b0) begin bad++; $error("FAIL rst_overrun_err: %0h", overrun_err); end
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL rst_busy: %0h", busy); end
    rst = 1'b1;
    wait_ticks(4);

    s_sh = n_shift; s_ld = n_ld; s_fe = n_fe; s_cen = n_cen;
    send_frame(8'hA5, 1'b1);
    total++; if (n_shift - s_sh !== 8) begin bad++; $error("FAIL t1_shift_count: %0d", n_shift - s_sh); end
    total++; if (get_byte(s_sh) !== 8'hA5) begin bad++; $error("FAIL t1_bits: %0h", get_byte(s_sh)); end
    total++; if (shift_time[8'(s_sh + 1)] - shift_time[8'(s_sh)] !== 64) begin bad++; $error("FAIL t1_spacing"); end
    total++; if (shift_time[8'(s_sh + 7)] - shift_time[8'(s_sh)] !== 448) begin bad++; $error("FAIL t1_span"); end
    total++; if (n_cen - s_cen !== 512) begin bad++; $error("FAIL t1_count_enb_cycles: %0d", n_cen - s_cen); end
    total++; if (n_ld - s_ld !== 1) begin bad++; $error("FAIL t1_ld_count: %0d", n_ld - s_ld); end
    total++; if (n_fe - s_fe !== 0) begin bad++; $error("FAIL t1_frame_err: %0d", n_fe - s_fe); end
    total++; if (rx_valid !== 1'b1) begin bad++; $error("FAIL t1_rx_valid: %0h", rx_valid); end
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL t1_busy: %0h", busy); end
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    total++; if (rx_valid !== 1'b0) begin bad++; $error("FAIL t1_valid_cleared: %0h", rx_valid); end

    s_sh = n_shift; s_ld = n_ld; s_fe = n_fe;
    rx_in = 1'b0;
    wait_ticks(3);
    total++; if (busy !== 1'b1) begin bad++; $error("FAIL t2_busy_in_start: %0h", busy); end
    rx_in = 1'b1;
    wait_ticks(12);
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL t2_busy_idle: %0h", busy); end
    total++; if (n_shift - s_sh !== 0) begin bad++; $error("FAIL t2_no_shift: %0d", n_shift - s_sh); end
    total++; if (n_ld - s_ld !== 0) begin bad++; $error("FAIL t2_no_ld: %0d", n_ld - s_ld); end
    total++; if (n_fe - s_fe !== 0) begin bad++; $error("FAIL t2_no_fe: %0d", n_fe - s_fe); end

    s_sh = n_shift; s_ld = n_ld; s_fe = n_fe;
    send_frame(8'h3C, 1'b0);
    wait_ticks(40);
    total++; if (n_shift - s_sh !== 8) begin bad++; $error("FAIL t3_shift_count: %0d", n_shift - s_sh); end
    total++; if (get_byte(s_sh) !== 8'h3C) begin bad++; $error("FAIL t3_bits: %0h", get_byte(s_sh)); end
    total++; if (n_fe - s_fe !== 1) begin bad++; $error("FAIL t3_frame_err: %0d", n_fe - s_fe); end
    total++; if (n_ld - s_ld !== 0) begin bad++; $error("FAIL t3_no_ld: %0d", n_ld - s_ld); end
    total++; if (busy !== 1'b1) begin bad++; $error("FAIL t3_busy_brk: %0h", busy); end
    total++; if (rx_valid !== 1'b0) begin bad++; $error("FAIL t3_rx_valid: %0h", rx_valid); end
    rx_in = 1'b1;
    wait_ticks(2);
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL t3_busy_idle: %0h", busy); end

    s_sh = n_shift; s_ld = n_ld; s_ov = n_ov;
    send_frame(8'h11, 1'b1);
    total++; if (rx_valid !== 1'b1) begin bad++; $error("FAIL t4_first_valid: %0h", rx_valid); end
    total++; if (n_ov - s_ov !== 0) begin bad++; $error("FAIL t4_first_no_ov: %0d", n_ov - s_ov); end
    send_frame(8'h22, 1'b1);
    total++; if (n_shift - s_sh !== 16) begin bad++; $error("FAIL t4_shift_count: %0d", n_shift - s_sh); end
    total++; if (get_byte(s_sh + 8) !== 8'h22) begin bad++; $error("FAIL t4_second_bits: %0h", get_byte(s_sh + 8)); end
    total++; if (n_ld - s_ld !== 2) begin bad++; $error("FAIL t4_ld_count: %0d", n_ld - s_ld); end
    total++; if (n_ov - s_ov !== 1) begin bad++; $error("FAIL t4_overrun: %0d", n_ov - s_ov); end
    total++; if (rx_valid !== 1'b1) begin bad++; $error("FAIL t4_valid_held: %0h", rx_valid); end
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    total++; if (rx_valid !== 1'b0) begin bad++; $error("FAIL t4_valid_cleared: %0h", rx_valid); end

    s_ld = n_ld; s_ov = n_ov;
    send_frame(8'h55, 1'b1);
    total++; if (rx_valid !== 1'b1) begin bad++; $error("FAIL t5_first_valid: %0h", rx_valid); end
    send_head(8'hAA);
    rx_in = 1'b1;
    n = 0;
    while (ld_data !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++; if (ld_data !== 1'b1) begin bad++; $error("FAIL t5_ld_seen: %0h", ld_data); end
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    total++; if (rx_valid !== 1'b1) begin bad++; $error("FAIL t5_valid_kept: %0h", rx_valid); end
    repeat (4) @(negedge clk);
    total++; if (n_ov - s_ov !== 0) begin bad++; $error("FAIL t5_no_overrun: %0d", n_ov - s_ov); end
    total++; if (n_ld - s_ld !== 2) begin bad++; $error("FAIL t5_ld_count: %0d", n_ld - s_ld); end
    wait_ticks(10);

    s_sh = n_shift; s_ld = n_ld;
    rx_in = 1'b0;
    wait_ticks(16);
    for (int unsigned i = 0; i < 3; i++) begin
      rx_in = 1'b0;
      wait_ticks(16);
    end
    rx_in = 1'b0;
    n = 0;
    while (n_shift != s_sh + 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++; if (n_shift - s_sh !== 4) begin bad++; $error("FAIL t6_four_shifts: %0d", n_shift - s_sh); end
    #2 rst = 1'b0;
    #1;
    total++; if (count_enb !== 1'b0) begin bad++; $error("FAIL t6_count_enb: %0h", count_enb); end
    total++; if (busy !== 1'b0) begin bad++; $error("FAIL t6_busy: %0h", busy); end
    total++; if (rx_valid !== 1'b0) begin bad++; $error("FAIL t6_rx_valid: %0h", rx_valid); end
    total++; if (sampled_bit !== 1'b1) begin bad++; $error("FAIL t6_sampled_bit: %0h", sampled_bit); end
    total++; if (shift_en !== 1'b0) begin bad++; $error("FAIL t6_shift_en: %0h", shift_en); end
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_ticks(4);
    total++; if (n_ld - s_ld !== 0) begin bad++; $error("FAIL t6_aborted_no_ld: %0d", n_ld - s_ld); end
    s_sh = n_shift; s_ld = n_ld;
    send_frame(8'h0F, 1'b1);
    total++; if (n_shift - s_sh !== 8) begin bad++; $error("FAIL t6_shift_count: %0d", n_shift - s_sh); end
    total++; if (get_byte(s_sh) !== 8'h0F) begin bad++; $error("FAIL t6_bits: %0h", get_byte(s_sh)); end
    total++; if (n_ld - s_ld !== 1) begin bad++; $error("FAIL t6_ld_count: %0d", n_ld - s_ld); end
    total++; if (rx_valid !== 1'b1) begin bad++; $error("FAIL t6_valid: %0h", rx_valid); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
